// File: rtl/br_predict_btb.sv
// Branch predictor / branch target buffer for the pipelined MIPS datapath.
// A direct-mapped, tagged table in which each entry holds a valid bit, a tag,
// a target and a CNT_W-bit saturating counter. It also runs a multi-cycle
// invalidation sweep and keeps a saturating mispredict statistic.
// Ports:
//   CLK, nRST        clock (rising edge), synchronous active-low reset
//   lookup_pc        fetch PC; predict/hit/target/index are combinational from it
//   upd_*            resolved-branch update; applied at the next rising edge
//   flush_req        start a full-table invalidation sweep
//   busy             sweep in progress (registered state)
//   mispred_count    saturating count of upd_en & upd_mispredict
module br_predict_btb #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = $clog2(ENTRIES),
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned STAT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [31:0]       lookup_pc,
  output logic              predict,
  output logic              hit,
  output logic [31:0]       target,
  output logic [IDX_W-1:0]  index,
  input  logic              upd_en,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_mispredict,
  input  logic              flush_req,
  output logic              busy,
  output logic [STAT_W-1:0] mispred_count
);

  localparam int unsigned TAG_LO = IDX_W + 2;
  localparam int unsigned TAG_HI = IDX_W + TAG_W + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_WEAK = CNT_W'(1) << (CNT_W - 1);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  typedef enum logic {S_IDLE, S_SWEEP} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               valid_q [ENTRIES];
  logic               valid_d [ENTRIES];
  logic [TAG_W-1:0]   tag_q   [ENTRIES];
  logic [TAG_W-1:0]   tag_d   [ENTRIES];
  logic [31:0]        tgt_q   [ENTRIES];
  logic [31:0]        tgt_d   [ENTRIES];
  logic [CNT_W-1:0]   cnt_q   [ENTRIES];
  logic [CNT_W-1:0]   cnt_d   [ENTRIES];
  logic [STAT_W-1:0]  mis_q, mis_d;

  logic [TAG_W-1:0]   lk_tag;
  logic [IDX_W-1:0]   u_idx;
  logic [TAG_W-1:0]   u_tag;
  logic               u_hit;

  // PC bits below the index and above the tag take no part in the lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[1:0], lookup_pc[31:TAG_HI+1],
                            upd_pc[1:0], upd_pc[31:TAG_HI+1]};

  // Zero-latency lookup against the registered table; no update bypass.
  assign index         = lookup_pc[TAG_LO-1:2];
  assign lk_tag        = lookup_pc[TAG_HI:TAG_LO];
  assign busy          = (state_q == S_SWEEP);
  assign hit           = valid_q[index] & (tag_q[index] == lk_tag) & ~busy;
  assign predict       = hit & cnt_q[index][CNT_W-1];
  assign target        = hit ? tgt_q[index] : '0;
  assign mispred_count = mis_q;

  assign u_idx = upd_pc[TAG_LO-1:2];
  assign u_tag = upd_pc[TAG_HI:TAG_LO];
  assign u_hit = valid_q[u_idx] & (tag_q[u_idx] == u_tag);

  // Next-state: table update in IDLE, one entry cleared per cycle in SWEEP.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;

    // Statistics are counted in every state.
    if (upd_en && upd_mispredict && (mis_q != STAT_MAX)) begin
      mis_d = mis_q + STAT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (upd_en) begin
          if (u_hit) begin
            if (upd_taken) begin
              if (cnt_q[u_idx] != CNT_MAX) cnt_d[u_idx] = cnt_q[u_idx] + CNT_W'(1);
              tgt_d[u_idx] = upd_target;
            end else if (cnt_q[u_idx] != '0) begin
              cnt_d[u_idx] = cnt_q[u_idx] - CNT_W'(1);
            end
          end else if (upd_taken) begin
            // Taken miss overwrites the slot as weakly taken.
            valid_d[u_idx] = 1'b1;
            tag_d[u_idx]   = u_tag;
            tgt_d[u_idx]   = upd_target;
            cnt_d[u_idx]   = CNT_WEAK;
          end
        end
        if (flush_req) begin
          state_d = S_SWEEP;
          ptr_d   = '0;
        end
      end
      S_SWEEP: begin
        valid_d[ptr_q] = 1'b0;
        cnt_d[ptr_q]   = '0;
        ptr_d          = ptr_q + IDX_W'(1);
        if (ptr_q == IDX_W'(ENTRIES - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and table registers; reset also aborts any sweep in flight.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      mis_q   <= '0;
      valid_q <= '{default: 1'b0};
      tag_q   <= '{default: '0};
      tgt_q   <= '{default: '0};
      cnt_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mis_q   <= mis_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
